// File: rtl/sync_ptr_multi_if.sv
// Bundle between the write-pointer source / rclk-domain consumer and sync_ptr_multi.
// Latency: none (wires only).
// Backpressure: none; pointers are sampled every cycle.
// Ports: wptr, err_clr toward the synchroniser; sync_gray, sync_bin, ptr_chg, gray_err,
//   armed back to the consumer. Channel k occupies [k*(ADDRSIZE+1) +: ADDRSIZE+1].
interface sync_ptr_multi_if #(
  parameter int ADDRSIZE = 32,
  parameter int NCH      = 1
);
  localparam int PW = NCH * (ADDRSIZE + 1);

  logic [PW-1:0]  wptr;
  logic           err_clr;
  logic [PW-1:0]  sync_gray;
  logic [PW-1:0]  sync_bin;
  logic [NCH-1:0] ptr_chg;
  logic [NCH-1:0] gray_err;
  logic           armed;

  modport master (
    output wptr, err_clr,
    input  sync_gray, sync_bin, ptr_chg, gray_err, armed
  );

  modport slave (
    input  wptr, err_clr,
    output sync_gray, sync_bin, ptr_chg, gray_err, armed
  );
endinterface

// File: rtl/sync_ptr_multi.sv
// Multi-channel gray-pointer synchroniser into rclk with gray->bin, change strobe, integrity check.
// Latency: wptr -> sync_gray STAGES edges; -> sync_bin / ptr_chg / gray_err STAGES+1 edges.
// Backpressure: none; every channel is sampled every rclk cycle.
// Ports: rclk (posedge), rrst (async, active-high), bus (slave side of sync_ptr_multi_if):
//   wptr/err_clr in, sync_gray/sync_bin/ptr_chg/gray_err/armed out.
module sync_ptr_multi #(
  parameter int ADDRSIZE = 32,
  parameter int STAGES   = 2,
  parameter int NCH      = 1
) (
  input  logic             rclk,
  input  logic             rrst,
  sync_ptr_multi_if.slave  bus
);
  localparam int W  = ADDRSIZE + 1;
  localparam int CW = $clog2(STAGES + 2);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ptr_multi: STAGES must be >= 2");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("sync_ptr_multi: NCH must be >= 1");
  end

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Warm-up: the integrity check stays off until the chain and prev copy have been
  // refilled from wptr, so the reset-to-first-value step is never flagged.
  logic [CW-1:0] cnt_q;
  logic          armed_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (cnt_q != CW'(STAGES + 1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // cnt_q reaches STAGES+1 on this edge
      if (cnt_q == CW'(STAGES)) begin
        armed_q <= 1'b1;
      end
    end
  end

  logic [NCH-1:0][W-1:0] gray_all;
  logic [NCH-1:0][W-1:0] bin_all;
  logic [NCH-1:0]        chg_all;
  logic [NCH-1:0]        err_all;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [W-1:0] s [STAGES];
    logic [W-1:0] prev_q;
    logic [W-1:0] bin_q;
    logic         chg_q;
    logic         err_q;
    logic [W-1:0] diff;
    logic         multi;

    assign diff  = s[STAGES-1] ^ prev_q;
    // clearing the lowest set bit leaves something only if two or more bits differ
    assign multi = |(diff & (diff - W'(1)));

    always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
        for (int i = 0; i < STAGES; i++) begin
          s[i] <= '0;
        end
        prev_q <= '0;
        bin_q  <= '0;
        chg_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        s[0] <= bus.wptr[k*W +: W];
        for (int i = 1; i < STAGES; i++) begin
          s[i] <= s[i-1];
        end
        prev_q <= s[STAGES-1];
        bin_q  <= gray2bin(s[STAGES-1]);
        chg_q  <= (diff != '0);
        // a new error outranks a coincident clear
        if (armed_q && multi) begin
          err_q <= 1'b1;
        end else if (bus.err_clr) begin
          err_q <= 1'b0;
        end
      end
    end

    assign gray_all[k] = s[STAGES-1];
    assign bin_all[k]  = bin_q;
    assign chg_all[k]  = chg_q;
    assign err_all[k]  = err_q;
  end

  assign bus.sync_gray = gray_all;
  assign bus.sync_bin  = bin_all;
  assign bus.ptr_chg   = chg_all;
  assign bus.gray_err  = err_all;
  assign bus.armed     = armed_q;
endmodule
